// File: rtl/key_guard.sv
// Gates debounced key-press pulses by the protector's lock level and blinks led_rej on rejected presses.
// Optional saturating reject counter on rej_cnt when KEY_GUARD_REJCNT_EN is defined.

`ifndef C_MS
`define C_MS(ms) ((ms) * 50_000)
`endif

module key_guard #(
    parameter int unsigned N          = 4,
    parameter int unsigned BLINK_CMAX = `C_MS(125),
    parameter int unsigned BLINKS     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lock,
    input  logic         tr_lck,
    input  logic [N-1:0] key,
    input  logic [N-1:0] pe_key,
    output logic [N-1:0] pe_out,
    output logic         led_rej,
    output logic         armed,
    output logic [7:0]   rej_cnt
);

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        ARMING = 2'd1,
        OPEN   = 2'd2
    } state_t;

    localparam int unsigned HW = (BLINK_CMAX > 1) ? $clog2(BLINK_CMAX) : 1;
    localparam int unsigned PW = (BLINKS > 1) ? $clog2(BLINKS) : 1;
    localparam logic [HW-1:0] HALF_LAST  = HW'(BLINK_CMAX - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(BLINKS - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   pe_out_q, pe_out_d;
    logic           armed_q, armed_d;
    logic           led_q, led_d;
    logic           blink_act_q, blink_act_d;
    logic [HW-1:0]  half_cnt_q, half_cnt_d;
    logic [PW-1:0]  pulse_cnt_q, pulse_cnt_d;

    logic           pass_en;
    logic           rej_event;
    logic [N-1:0]   pe_gated;

    // Presses pass only while already open and not being locked this very cycle.
    assign pass_en   = (state_q == OPEN) && !lock;
    assign rej_event = (state_q == LOCKED) && lock && (|pe_key);

    for (genvar gi = 0; gi < N; gi++) begin : g_gate
        assign pe_gated[gi] = pe_key[gi] & pass_en;
    end

    always_comb begin
        state_d = state_q;
        if (lock) begin
            state_d = LOCKED;
        end else begin
            case (state_q)
                LOCKED:  state_d = ARMING;
                ARMING:  if (~|key) state_d = OPEN;
                OPEN:    state_d = OPEN;
                default: state_d = ARMING;
            endcase
        end
        armed_d  = (state_d == OPEN);
        pe_out_d = pe_gated;
    end

    // A lock toggle aborts the blink outright, even against a coincident reject.
    always_comb begin
        blink_act_d = blink_act_q;
        led_d       = led_q;
        half_cnt_d  = half_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        if (tr_lck) begin
            blink_act_d = 1'b0;
            led_d       = 1'b0;
            half_cnt_d  = '0;
            pulse_cnt_d = '0;
        end else if (rej_event) begin
            blink_act_d = 1'b1;
            led_d       = 1'b1;
            half_cnt_d  = '0;
            pulse_cnt_d = '0;
        end else if (blink_act_q) begin
            if (half_cnt_q == HALF_LAST) begin
                half_cnt_d = '0;
                if (led_q) begin
                    led_d = 1'b0;
                end else if (pulse_cnt_q == PULSE_LAST) begin
                    blink_act_d = 1'b0;
                    pulse_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                    led_d       = 1'b1;
                end
            end else begin
                half_cnt_d = half_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARMING;
            pe_out_q    <= '0;
            armed_q     <= 1'b0;
            led_q       <= 1'b0;
            blink_act_q <= 1'b0;
            half_cnt_q  <= '0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pe_out_q    <= pe_out_d;
            armed_q     <= armed_d;
            led_q       <= led_d;
            blink_act_q <= blink_act_d;
            half_cnt_q  <= half_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

`ifdef KEY_GUARD_REJCNT_EN
    logic [7:0] rej_cnt_q, rej_cnt_d;
    logic       unlock_entry;

    assign unlock_entry = (state_q == LOCKED) && !lock;

    always_comb begin
        rej_cnt_d = rej_cnt_q;
        if (unlock_entry) begin
            rej_cnt_d = '0;
        end else if (rej_event && (rej_cnt_q != 8'hFF)) begin
            rej_cnt_d = rej_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_cnt_q <= '0;
        end else begin
            rej_cnt_q <= rej_cnt_d;
        end
    end

    assign rej_cnt = rej_cnt_q;
`else
    assign rej_cnt = '0;
`endif

    assign pe_out  = pe_out_q;
    assign led_rej = led_q;
    assign armed   = armed_q;

endmodule

// File: tb/tb_key_guard.sv
// Scoreboard bench for key_guard: a cycle model pushes expected outputs per driven cycle,
// popped and compared one cycle later; blink patterns are also checked against fixed sequences.

module tb_key_guard;

    localparam int N    = 4;
    localparam int CMAX = 4;
    localparam int NB   = 2;
`ifdef KEY_GUARD_REJCNT_EN
    localparam bit REJ_EN = 1'b1;
`else
    localparam bit REJ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         lock = 1'b0;
    logic         tr_lck = 1'b0;
    logic [N-1:0] key = '0;
    logic [N-1:0] pe_key = '0;
    logic [N-1:0] pe_out;
    logic         led_rej;
    logic         armed;
    logic [7:0]   rej_cnt;

    key_guard #(.N(N), .BLINK_CMAX(CMAX), .BLINKS(NB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lock    (lock),
        .tr_lck  (tr_lck),
        .key     (key),
        .pe_key  (pe_key),
        .pe_out  (pe_out),
        .led_rej (led_rej),
        .armed   (armed),
        .rej_cnt (rej_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] pe;
        logic         led;
        logic         armed;
        logic [7:0]   rej;
    } exp_t;

    exp_t sb_q[$];
    int   check_cnt = 0;
    int   err_cnt   = 0;

    // Reference model: 0 = LOCKED, 1 = ARMING, 2 = OPEN; blink tracked by age since start.
    int   m_state;
    bit   m_act;
    int   m_age;
    int   m_rej;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 1;
        m_act   = 1'b0;
        m_age   = 0;
        m_rej   = 0;
    endtask

    task automatic do_reset(input logic [N-1:0] k);
        rst_n  = 1'b0;
        lock   = 1'b0;
        tr_lck = 1'b0;
        key    = k;
        pe_key = '0;
        #2;
        check_eq("rst_pe_out", 32'(pe_out), 32'd0);
        check_eq("rst_led", 32'(led_rej), 32'd0);
        check_eq("rst_armed", 32'(armed), 32'd0);
        check_eq("rst_rej", 32'(rej_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        sb_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic step(input logic lk, input logic tr, input logic [N-1:0] k, input logic [N-1:0] pe);
        exp_t e;
        bit   rej_ev;
        int   nstate;
        lock   = lk;
        tr_lck = tr;
        key    = k;
        pe_key = pe;
        rej_ev = (m_state == 0) && lk && (pe != '0);
        e.pe   = (m_state == 2 && !lk) ? pe : '0;
        if (lk)                nstate = 0;
        else if (m_state == 0) nstate = 1;
        else if (m_state == 1) nstate = (k == '0) ? 2 : 1;
        else                   nstate = 2;
        if (tr) begin
            m_act = 1'b0;
            m_age = 0;
        end else if (rej_ev) begin
            m_act = 1'b1;
            m_age = 0;
        end else if (m_act) begin
            m_age++;
            if (m_age >= 2 * CMAX * NB) begin
                m_act = 1'b0;
                m_age = 0;
            end
        end
        e.led = m_act && ((m_age % (2 * CMAX)) < CMAX);
        if (m_state == 0 && !lk)        m_rej = 0;
        else if (rej_ev && m_rej < 255) m_rej++;
        e.rej   = REJ_EN ? 8'(m_rej) : 8'd0;
        m_state = nstate;
        e.armed = (nstate == 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("pe_out", 32'(pe_out), 32'(e.pe));
            check_eq("led_rej", 32'(led_rej), 32'(e.led));
            check_eq("armed", 32'(armed), 32'(e.armed));
            check_eq("rej_cnt", 32'(rej_cnt), 32'(e.rej));
        end
        if (pe != '0)
            $display("press lock=%0b tr=%0b key=%b pe_key=%b -> pe_out=%b led=%0b armed=%0b rej=%0d",
                     lk, tr, k, pe, pe_out, led_rej, armed, rej_cnt);
    endtask

    task automatic record(input int n, inout logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, '0, '0);
            pat = {pat[30:0], led_rej};
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", check_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat;
        #1;
        // Reset release with keys up, then a two-key press.
        do_reset('0);
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        check_eq("armed_after_release", 32'(armed), 32'd1);
        step(1'b0, 1'b0, '0, 4'b0101);
        check_eq("pass_0101", 32'(pe_out), 32'h5);
        step(1'b0, 1'b0, '0, '0);
        check_eq("pass_one_cycle", 32'(pe_out), 32'h0);
        step(1'b0, 1'b0, '0, 4'b1111);
        check_eq("pass_1111", 32'(pe_out), 32'hF);
        step(1'b0, 1'b0, '0, '0);

        // Lock and a press rising together while open.
        step(1'b1, 1'b1, '0, 4'b1000);
        check_eq("lock_edge_pe", 32'(pe_out), 32'h0);
        check_eq("lock_edge_armed", 32'(armed), 32'd0);
        check_eq("lock_edge_led", 32'(led_rej), 32'd0);
        check_eq("lock_edge_rej", 32'(rej_cnt), 32'd0);
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);

        // Single reject while locked.
        step(1'b1, 1'b0, '0, 4'b0001);
        check_eq("rej_pe_out", 32'(pe_out), 32'h0);
        check_eq("rej_cnt_1", 32'(rej_cnt), REJ_EN ? 32'd1 : 32'd0);
        pat = {31'd0, led_rej};
        record(16, pat);
        check_eq("blink_pat", pat, 32'b1_1110_0001_1110_0000);

        // Second press three cycles into a blink restarts it.
        step(1'b1, 1'b0, '0, 4'b0001);
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 4'b0010);
        pat = {31'd0, led_rej};
        record(16, pat);
        check_eq("restart_pat", pat, 32'b1_1110_0001_1110_0000);

        // Reject coincident with tr_lck aborts the running blink.
        step(1'b1, 1'b0, '0, 4'b0001);
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, '0, 4'b0001);
        pat = {31'd0, led_rej};
        record(6, pat);
        check_eq("abort_pat", pat, 32'd0);

        // Many rejects saturate the counter; unlocking clears it.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, '0, 4'b0100);
            step(1'b1, 1'b0, '0, '0);
        end
        check_eq("rej_sat", 32'(rej_cnt), REJ_EN ? 32'd255 : 32'd0);
        step(1'b0, 1'b1, '0, '0);
        check_eq("unlock_rej_clr", 32'(rej_cnt), 32'd0);
        check_eq("unlock_arming", 32'(armed), 32'd0);
        step(1'b0, 1'b0, '0, '0);
        check_eq("unlock_open", 32'(armed), 32'd1);

        // Asynchronous reset in the middle of a blink.
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 4'b0001);
        step(1'b1, 1'b0, '0, '0);
        check_eq("pre_reset_led", 32'(led_rej), 32'd1);

        // Reset release with a key still held.
        do_reset(4'b0010);
        step(1'b0, 1'b0, 4'b0010, 4'b0010);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 4'b0010, '0);
        check_eq("held_armed", 32'(armed), 32'd0);
        check_eq("held_pe_out", 32'(pe_out), 32'h0);
        step(1'b0, 1'b0, '0, '0);
        check_eq("release_armed", 32'(armed), 32'd1);
        step(1'b0, 1'b0, '0, 4'b0010);
        check_eq("post_release_pass", 32'(pe_out), 32'h2);
        step(1'b0, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
